flash_sample_reader: RTL

FLASH_SAMPLE_READER -- requirements
Module: flash_sample_reader

---
 rtl/flash_sample_reader.sv | 118 +++++++++++
 1 files changed

// File: rtl/flash_sample_reader.sv
// Streams 16-bit audio samples out of 32-bit flash words: one Avalon read feeds two
// sample ticks, with halfword order picked by the playback direction.
module flash_sample_reader #(
  parameter int FLASH_AW = 23
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                sample_tick,
  input  logic [31:0]         curr_addr,
  input  logic                forward,
  input  logic                flush,
  output logic                flash_mem_read,
  output logic [FLASH_AW-1:0] flash_mem_address,
  output logic [3:0]          flash_mem_byteenable,
  input  logic                flash_mem_waitrequest,
  input  logic [31:0]         flash_mem_readdata,
  input  logic                flash_mem_readdatavalid,
  output logic [15:0]         audio_data,
  output logic                sample_valid,
  output logic                addr_advance,
  output logic                overrun
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT_DATA, HALF_READY} state_t;

  state_t      state, nxt_state;
  logic        tick_d, tick_edge;
  logic        fwd, discard;
  logic [15:0] held;
  logic        start_rd, ld_first, ld_second, set_ovr, set_discard;

  assign tick_edge = sample_tick & ~tick_d;

  if (FLASH_AW < 32) begin : g_unused
    logic unused_hi;
    assign unused_hi = ^curr_addr[31:FLASH_AW];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= nxt_state;
  end

  always_comb begin
    nxt_state   = state;
    start_rd    = 1'b0;
    ld_first    = 1'b0;
    ld_second   = 1'b0;
    set_ovr     = 1'b0;
    set_discard = 1'b0;
    case (state)
      IDLE: if (!flush && tick_edge) begin
        nxt_state = REQ;
        start_rd  = 1'b1;
      end
      REQ: begin
        // the transaction must finish even when flushed; only its data is dropped
        set_ovr     = tick_edge & ~flush;
        set_discard = flush;
        if (!flash_mem_waitrequest) nxt_state = WAIT_DATA;
      end
      WAIT_DATA: begin
        set_ovr = tick_edge & ~flush;
        if (flash_mem_readdatavalid) begin
          nxt_state = (flush || discard) ? IDLE : HALF_READY;
          ld_first  = ~(flush | discard);
        end else begin
          set_discard = flush;
        end
      end
      HALF_READY: begin
        if (flush) nxt_state = IDLE;
        else if (tick_edge) begin
          nxt_state = IDLE;
          ld_second = 1'b1;
        end
      end
      default: nxt_state = IDLE;
    endcase
  end

  always_comb begin
    flash_mem_read       = (state == REQ);
    flash_mem_byteenable = 4'hF;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tick_d            <= 1'b0;
      fwd               <= 1'b0;
      discard           <= 1'b0;
      held              <= '0;
      flash_mem_address <= '0;
      audio_data        <= '0;
      sample_valid      <= 1'b0;
      addr_advance      <= 1'b0;
      overrun           <= 1'b0;
    end else begin
      tick_d       <= sample_tick;
      sample_valid <= ld_first | ld_second;
      addr_advance <= ld_second;
      if (set_ovr) overrun <= 1'b1;
      if (start_rd) begin
        flash_mem_address <= curr_addr[FLASH_AW-1:0];
        fwd               <= forward;
        discard           <= 1'b0;
      end else if (set_discard) begin
        discard <= 1'b1;
      end
      if (ld_first) begin
        audio_data <= fwd ? flash_mem_readdata[15:0]  : flash_mem_readdata[31:16];
        held       <= fwd ? flash_mem_readdata[31:16] : flash_mem_readdata[15:0];
      end
      if (ld_second) audio_data <= held;
    end
  end

endmodule
